// File: rtl/size_cast_pkg.sv
// size_cast_pkg
//   Shared helpers for the size-cast gearbox blocks:
//   - beats(in_w, out_w)    : number of narrow beats per wide word (ceiling division)
//   - rem_bits(in_w, out_w) : number of meaningful bits carried by the final beat
//   - idx_bits(in_w, out_w) : width of a beat index, never less than 1
//   - dsz_state_e           : downsizer FSM states
package size_cast_pkg;

  typedef enum logic {
    DSZ_IDLE,
    DSZ_SEND
  } dsz_state_e;

  function automatic int beats(input int in_w, input int out_w);
    return (in_w + out_w - 1) / out_w;
  endfunction

  function automatic int rem_bits(input int in_w, input int out_w);
    return in_w - (beats(in_w, out_w) - 1) * out_w;
  endfunction

  function automatic int idx_bits(input int in_w, input int out_w);
    int b;
    b = beats(in_w, out_w);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage : size_cast_pkg

// File: rtl/size_cast_downsizer.sv
// size_cast_downsizer
//   Streaming width-narrowing gearbox. Each accepted IN_WIDTH-bit word is emitted
//   as beats(IN_WIDTH, OUT_WIDTH) beats of OUT_WIDTH bits, least-significant first.
//   The final partial beat is sign-extended (SIGNED != 0) or zero-extended.
//
// Ports
//   clk        : clock, rising-edge
//   rst_n      : asynchronous active-low reset; discards any word in flight
//   in_valid   : input word present
//   in_ready   : block can accept a word (IDLE, or last beat leaving this cycle)
//   in_data    : input word
//   out_valid  : beat present
//   out_ready  : consumer accepts the beat
//   out_data   : current beat
//   out_last   : current beat is the final beat of its word
//   out_idx    : index of the current beat within its word, starting at 0
module size_cast_downsizer
  import size_cast_pkg::*;
#(
  parameter int IN_WIDTH  = 84,
  parameter int OUT_WIDTH = 32,
  parameter int SIGNED    = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [IN_WIDTH-1:0]                         in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [OUT_WIDTH-1:0]                        out_data,
  output logic                                        out_last,
  output logic [idx_bits(IN_WIDTH, OUT_WIDTH)-1:0]    out_idx
);

  localparam int BEATS  = beats(IN_WIDTH, OUT_WIDTH);
  localparam int IDX_W  = idx_bits(IN_WIDTH, OUT_WIDTH);
  localparam int HOLD_W = BEATS * OUT_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  dsz_state_e         state;
  logic [IDX_W-1:0]   idx;
  logic [HOLD_W-1:0]  hold;
  logic [HOLD_W-1:0]  ext_data;
  logic               at_last;

  // A signed size cast replicates bit IN_WIDTH-1; an unsigned one pads zeros.
  // When HOLD_W == IN_WIDTH both casts are plain copies.
  assign ext_data = (SIGNED != 0) ? HOLD_W'($signed(in_data)) : HOLD_W'(in_data);

  assign at_last   = (idx == LAST_IDX);
  assign out_valid = (state == DSZ_SEND);
  assign out_last  = out_valid && at_last;
  assign out_idx   = idx;
  // The current beat always sits at the bottom of the holding register; it is
  // shifted down one beat per handshake instead of being indexed by idx.
  assign out_data  = hold[OUT_WIDTH-1:0];
  assign in_ready  = (state == DSZ_IDLE) || (out_last && out_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DSZ_IDLE;
      idx   <= '0;
      // NOTE: the holding register is reset because out_data is read straight
      // from it and must be zero out of reset.
      hold  <= '0;
    end else begin
      case (state)
        DSZ_IDLE: begin
          if (in_valid) begin
            hold  <= ext_data;
            idx   <= '0;
            state <= DSZ_SEND;
          end
        end
        DSZ_SEND: begin
          if (out_ready) begin
            if (at_last) begin
              idx <= '0;
              // in_ready is high here, so in_valid alone means a handshake.
              if (in_valid) begin
                hold <= ext_data;
              end else begin
                state <= DSZ_IDLE;
              end
            end else begin
              idx  <= idx + IDX_W'(1);
              hold <= hold >> OUT_WIDTH;
            end
          end
        end
        default: state <= DSZ_IDLE;
      endcase
    end
  end

endmodule : size_cast_downsizer

// File: doc/size_cast_downsizer.md
# size_cast_downsizer

Streaming width-narrowing gearbox, the inverse of a widening size cast. Accepts one `IN_WIDTH`-bit word per handshake and emits it as `ceil(IN_WIDTH/OUT_WIDTH)` narrow beats, least-significant beat first. The final partial beat is padded by sign extension (`SIGNED=1`) or zero extension (`SIGNED=0`), matching the language's size-cast rules. It sits between wide elaborated datapaths and narrow output channels in the simulation/back-end test harnesses.

## Interface
- `IN_WIDTH`, default 84: input word width; must be ≥ 1.
- `OUT_WIDTH`, default 32: output beat width; must be ≥ 1 and ≤ `IN_WIDTH`.
- `SIGNED`, default 1: pad the last beat with bit `IN_WIDTH-1` (1) or with zeros (0).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  `IN_WIDTH`  input word.
- `out_valid`  out  1  beat present.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  `OUT_WIDTH`  current beat.
- `out_last`  out  1  current beat is the final beat of the word.
- `out_idx`  out  `max(1,$clog2(BEATS))`  beat index, starting at 0.

## Operation
- `BEATS = ceil(IN_WIDTH/OUT_WIDTH)`.
- `REM = IN_WIDTH - (BEATS-1)*OUT_WIDTH`; this is the number of valid bits in the last beat.
- Input acceptance:
  - A word is accepted when `in_valid && in_ready`.
  - The word is captured into a holding register pre-extended to `BEATS*OUT_WIDTH` bits (sign- or zero-extended per `SIGNED`).
- Beat *k* of a word is `hold[k*OUT_WIDTH +: OUT_WIDTH]`.
- FSM states:
  - IDLE: `out_valid=0`, `in_ready=1`. Accept → SEND with `idx=0`.
  - SEND: `out_valid=1`.
    - When `out_ready` is high and `idx < BEATS-1`: `idx++`.
    - When `out_ready` is high and `idx == BEATS-1` (the last beat): go to IDLE, unless a new word is accepted in the same cycle, in which case stay in SEND with `idx=0`.
- `in_ready = (state==IDLE) || (out_last && out_ready)`. This gives back-to-back words with no bubble.
- `out_last = out_valid && idx==BEATS-1`.
- `BEATS==1` (`OUT_WIDTH==IN_WIDTH`): every beat is last; the block behaves as a one-deep pipeline register.
- Output stability: `out_data`, `out_idx` and `out_last` hold steady while `out_valid && !out_ready`.
- Asserting `rst_n` low mid-word discards the partial word. No beats of it are emitted after reset.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_idx=0`, `in_ready=1` (combinational from IDLE). State = IDLE, holding register = 0.
- Latency: the first beat is valid in the cycle after the input handshake.
- Throughput: one beat per cycle while `out_ready=1`. This is `BEATS` cycles per word with no idle cycles between words.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` or `in_data` to any output.
- Rules: `out_valid` never drops without a handshake. `in_data` is ignored when `!in_valid`.

## Structure
- Package `size_cast_pkg` holds:
  - function `beats(in_w, out_w)` (ceiling division);
  - function `rem_bits(in_w, out_w)`;
  - typedef enum `dsz_state_e {DSZ_IDLE, DSZ_SEND}`.
- Pad/extension logic is a single continuous assignment inside the module.
- Sub-modules: none. One FSM, one counter and one holding register do not justify splitting the block.

## Test plan
- **Signed, partial last beat.** `IN=84`, `OUT=32`, `SIGNED=1`, `in_data=84'h8_0000_AAAA_BBBB_CCCC_DDDD`, `out_ready=1`.
  - Required beats: `CCCCDDDD`, `AAAABBBB`, `FFF80000`.
  - `out_last` high on the third beat only; `out_idx` = 0, 1, 2.
- **Unsigned, same word.** Same stimulus with `SIGNED=0`. The last beat is `00080000`.
- **Back-to-back words.** Two words presented on consecutive `in_ready` cycles.
  - Required: six consecutive valid beats with no bubble.
  - `in_ready` pulses only in the cycle the third beat handshakes.
- **Backpressure.** `out_ready` is held low for 5 cycles on beat 1.
  - `out_data=AAAABBBB` and `out_idx=1` stay stable throughout.
  - `in_ready` stays 0 throughout.
  - Beat 2 follows one cycle after `out_ready` rises.
- **Reset mid-word.** `rst_n` pulsed low after beat 0.
  - `out_valid` drops to 0 asynchronously.
  - After release, `in_ready=1` and no stale beats appear.
- **Single-beat configuration.** `IN=OUT=32`, `in_data=32'hDEADBEEF`.
  - Required: one beat `DEADBEEF` with `out_last=1` and `out_idx=0`, one cycle after acceptance.
